fifo_uart_tx: RTL and testbench

- Read-side consumer for the FIFO pointer/flag controller.
- Watches the FIFO empty flag and pulls one word at a time by pulsing take.
- Captures the word presented at the read pointer and serialises it as an 8N1-style UART frame: start bit, DATA_WIDTH data bits LSB first, one stop bit.
- Sits between the FIFO storage and the board TX pin; this is the draining end of the FIFO.

---
 rtl/fifo_uart_tx.sv | 131 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO read-side drain: pulls one word whenever the FIFO is non-empty and
// shifts it out as a UART frame (start bit, DATA_WIDTH data bits LSB first, stop bit).
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_take,
    output logic                  out_tx,
    output logic                  out_busy,
    output logic [1:0]            out_state
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [BAUD_W-1:0]     baud, baud_n;
    logic [BIT_W-1:0]      bit_idx, bit_idx_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  tx_q, tx_n;
    logic                  take_q, take_n;
    logic                  busy_q, busy_n;
    logic                  baud_last;

    assign baud_last = (baud == BAUD_LAST);
    assign shifted   = shift >> 1;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
            take_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
            take_q  <= take_n;
            busy_q  <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud_last ? '0 : baud + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx_q;
        take_n    = 1'b0;
        busy_n    = busy_q;

        case (state)
            IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (!in_empty) begin
                    shift_n = in_data;
                    take_n  = 1'b1;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (baud_last) begin
                    tx_n      = shift[0];
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_idx == BIT_LAST) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        shift_n   = shifted;
                        tx_n      = shifted[0];
                    end
                end
            end
            STOP: begin
                // Back-to-back frames: the next word is captured on the stop-bit's last edge.
                if (baud_last) begin
                    if (!in_empty) begin
                        shift_n = in_data;
                        take_n  = 1'b1;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign out_take  = take_q;
    assign out_tx    = tx_q;
    assign out_busy  = busy_q;
    assign out_state = state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue models the FIFO and the serial line
// is sampled every cycle and decoded against hand-computed frames.
module tb_fifo_uart_tx;

    localparam int W     = 8;
    localparam int C     = 4;
    localparam int FRAME = (W + 2) * C;

    logic         in_clock = 1'b0;
    logic         in_reset;
    logic         in_empty;
    logic [W-1:0] in_data;
    logic         out_take;
    logic         out_tx;
    logic         out_busy;
    logic [1:0]   out_state;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic         smp[0:3*FRAME-1];
    int           take_at[$];
    int           n_take;
    int           n_busy;

    fifo_uart_tx #(
        .DATA_WIDTH  (W),
        .CLKS_PER_BIT(C)
    ) dut (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_empty (in_empty),
        .in_data  (in_data),
        .out_take (out_take),
        .out_tx   (out_tx),
        .out_busy (out_busy),
        .out_state(out_state)
    );

    always #5 in_clock = ~in_clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        in_empty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) in_data = fifo_q[0];
    endtask

    // Controller model: a take pulse consumes the head word.
    task automatic step();
        @(posedge in_clock);
        #1;
        if (out_take === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive();
    endtask

    task automatic push(input logic [W-1:0] d, input bit expect_out);
        fifo_q.push_back(d);
        if (expect_out) exp_q.push_back(d);
        drive();
    endtask

    task automatic wait_take(input int limit, output int lat);
        lat = 0;
        while (out_take !== 1'b1 && lat < limit) begin
            step();
            lat++;
        end
        if (out_take !== 1'b1) check("take_timeout", 32'd0, 32'd1);
    endtask

    task automatic sample(input int n, input int poke_at, input logic [W-1:0] poke_val);
        n_take = 0;
        n_busy = 0;
        take_at.delete();
        for (int i = 0; i < n; i++) begin
            if (i == poke_at) in_data = poke_val;
            smp[i] = out_tx;
            if (out_take === 1'b1) begin
                n_take++;
                take_at.push_back(i);
            end
            if (out_busy === 1'b1) n_busy++;
            step();
        end
    endtask

    task automatic check_frame(input string tag, input int base, output logic [W+1:0] word);
        int           bad;
        logic [W-1:0] exp;
        bad = 0;
        for (int s = 0; s < W + 2; s++) begin
            word[s] = smp[base + s*C];
            for (int j = 0; j < C; j++)
                if (smp[base + s*C + j] !== word[s]) bad++;
        end
        check({tag, "_hold"}, bad, 0);
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, word, {1'b1, exp, 1'b0});
        end
    endtask

    initial begin
        int           lat;
        int           cnt_take;
        int           cnt_low;
        logic [W+1:0] word;

        in_reset = 1'b1;
        in_data  = '0;
        push(8'h5A, 1'b1);

        // Reset held with a non-empty FIFO: nothing may be taken.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tx", out_tx, 1);
            check("rst_take", out_take, 0);
            check("rst_busy", out_busy, 0);
        end
        in_reset = 1'b0;
        step();
        check("first_take", out_take, 1);
        check("first_tx", out_tx, 0);
        check("first_busy", out_busy, 1);
        sample(FRAME, -1, '0);
        check_frame("frame_5a", 0, word);
        check("5a_takes", n_take, 1);
        check("5a_idle_busy", out_busy, 0);

        // Single word 0xA5.
        push(8'hA5, 1'b1);
        wait_take(8, lat);
        check("a5_latency", lat, 1);
        sample(FRAME, -1, '0);
        check_frame("frame_a5", 0, word);
        check("a5_pattern", word, 10'h34A);
        check("a5_takes", n_take, 1);
        check("a5_busy_cycles", n_busy, FRAME);
        check("a5_idle_busy", out_busy, 0);
        check("a5_idle_tx", out_tx, 1);
        check("a5_idle_state", out_state, 0);

        // Back-to-back frames.
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h3C, 1'b1);
        wait_take(8, lat);
        sample(3*FRAME, -1, '0);
        check("b2b_takes", n_take, 3);
        if (take_at.size() == 3) begin
            check("b2b_take0", take_at[0], 0);
            check("b2b_take1", take_at[1], FRAME);
            check("b2b_take2", take_at[2], 2*FRAME);
        end
        check("b2b_busy_cycles", n_busy, 3*FRAME);
        check_frame("frame_00", 0, word);
        check_frame("frame_ff", FRAME, word);
        check_frame("frame_3c", 2*FRAME, word);
        check("b2b_idle_busy", out_busy, 0);

        // Empty FIFO for 200 cycles.
        cnt_take = 0;
        cnt_low  = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (out_take !== 1'b0) cnt_take++;
            if (out_tx !== 1'b1) cnt_low++;
        end
        check("empty_takes", cnt_take, 0);
        check("empty_tx_low", cnt_low, 0);

        // Reset during data bit 3 of 0x55 (frame cycles 16..19).
        push(8'h55, 1'b0);
        wait_take(8, lat);
        sample(18, -1, '0);
        check("mid_bit3", out_tx, 0);
        check("mid_busy", out_busy, 1);
        in_reset = 1'b1;
        push(8'h81, 1'b1);
        step();
        check("mid_rst_tx", out_tx, 1);
        check("mid_rst_busy", out_busy, 0);
        check("mid_rst_take", out_take, 0);
        check("mid_rst_state", out_state, 0);
        in_reset = 1'b0;
        step();
        check("post_rst_take", out_take, 1);
        sample(FRAME, -1, '0);
        check_frame("frame_81", 0, word);
        check("81_takes", n_take, 1);
        check("81_idle_busy", out_busy, 0);

        // in_data changes one cycle after capture; the latched word must go out.
        push(8'h12, 1'b1);
        wait_take(8, lat);
        sample(FRAME, 1, 8'hEE);
        check_frame("frame_12", 0, word);
        check("12_idle_busy", out_busy, 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
